// File: rtl/key_event_packer_if.sv
// Byte-stream link from the key event packer to the UDP payload source.
// The packer drives data/valid/last and the sink answers with ready.
interface key_event_packer_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_last;

    modport master (
        output tx_data,
        output tx_valid,
        output tx_last,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        input  tx_last,
        output tx_ready
    );
endinterface

// File: rtl/key_event_packer.sv
// Key event packer.
// Each cycle with any key pulse becomes a two-byte record {seq, TAG|keys}.
// Records wait in a small FIFO and stream out byte by byte over valid/ready.
// Events that find the FIFO full are dropped and counted, so the host can
// detect loss. seq only advances for stored events, so gaps never appear.
module key_event_packer #(
    parameter int         DEPTH = 8,
    parameter logic [3:0] TAG   = 4'hA
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [3:0]               key_in,
    key_event_packer_if.master       tx,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [7:0]               drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    // Output sequencer states: nothing loaded, sending seq byte, sending key byte.
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] B0   = 2'd1;
    localparam logic [1:0] B1   = 2'd2;

    logic [11:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [7:0]    seq;

    logic [1:0]    state;
    logic [3:0]    out_key;
    logic [7:0]    data_q;
    logic          valid_q;
    logic          last_q;

    logic          key_event;
    logic          fifo_empty;
    logic          fifo_full;
    logic          xfer;
    logic          pop;
    logic          push;
    logic          drop;
    logic [11:0]   head;

    assign key_event  = (key_in != 4'd0);
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_LEVEL);
    assign xfer       = valid_q && tx.tx_ready;
    assign head       = mem[rd_ptr];

    // A pop loads the next record into the output register: either from IDLE,
    // or right as the key byte of the current record is accepted so records
    // stream back-to-back. A pop in the same cycle frees a slot for a push
    // even when the FIFO is full.
    always_comb begin
        pop  = 1'b0;
        push = 1'b0;
        drop = 1'b0;
        if (!fifo_empty) begin
            if (state == IDLE) begin
                pop = 1'b1;
            end else if (state == B1 && xfer) begin
                pop = 1'b1;
            end
        end
        if (key_event) begin
            if (!fifo_full || pop) begin
                push = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end
    end

    // FIFO storage holds {seq, keys}; contents need no reset since count gates reads.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {seq, key_in};
        end
    end

    // Pointers, occupancy, sequence number and the saturating drop counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            seq      <= 8'd0;
            drop_cnt <= 8'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
                seq    <= seq + 8'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (drop && drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    // Output sequencer: registers every output byte and holds it until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            out_key <= 4'd0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        out_key <= head[3:0];
                        data_q  <= head[11:4];
                        valid_q <= 1'b1;
                        last_q  <= 1'b0;
                        state   <= B0;
                    end
                end
                B0: begin
                    if (xfer) begin
                        data_q <= {TAG, out_key};
                        last_q <= 1'b1;
                        state  <= B1;
                    end
                end
                B1: begin
                    if (xfer) begin
                        if (pop) begin
                            out_key <= head[3:0];
                            data_q  <= head[11:4];
                            last_q  <= 1'b0;
                            state   <= B0;
                        end else begin
                            data_q  <= 8'h00;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end
                default: begin
                    data_q  <= 8'h00;
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign tx.tx_data  = data_q;
    assign tx.tx_valid = valid_q;
    assign tx.tx_last  = last_q;
    assign fifo_level  = count;

endmodule
